// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and a
// width helper used by the TX path and the later RX path.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef logic [2:0] tx_state_t;

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    // Ceiling log2; clog2(1) is 0 so callers must guarantee value >= 2.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rd_data always shows the head.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [clog2(DEPTH):0]  count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    // A push while full is dropped even if a pop happens on the same edge.
    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == {CW{1'b0}});
    assign wr_ok_s = wr_en && !full;
    assign rd_ok_s = rd_en && !empty;
    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-buffered words serialised as
// start / data (LSB first) / optional parity / stop bits on a registered line.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        tx,
    output logic                        busy,
    output logic                        tx_done,
    output logic [clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int CW = clog2(CLKS_PER_BIT);
    localparam int IW = 4;

    if (CLKS_PER_BIT < 4) begin : g_bad_clks
        $error("uart_tx_param: CLKS_PER_BIT must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_param: DATA_BITS must be within 5..9");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
    end

    function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
        logic p;
        p = ^d;
        if (PARITY == PAR_ODD) begin
            p = ~p;
        end else begin
            p = p;
        end
        return p;
    endfunction

    tx_state_t            state_r;
    logic [CW-1:0]        baud_cnt_r;
    logic [IW-1:0]        bit_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_r;
    logic                 tx_r;
    logic                 done_r;

    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [DATA_BITS-1:0] fifo_head_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 bit_end_s;
    logic                 data_last_s;
    logic                 stop_last_s;
    logic                 line_s;

    assign push_s  = s_valid && !fifo_full_s;
    assign s_ready = !fifo_full_s;
    assign tx      = tx_r;
    assign tx_done = done_r;
    assign busy    = (state_r != TX_IDLE) || !fifo_empty_s;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_s),
        .wr_data (s_data),
        .rd_en   (pop_s),
        .rd_data (fifo_head_s),
        .count   (fifo_count),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Bit-boundary decode and the line level implied by the current state.
    always_comb begin
        bit_end_s   = (baud_cnt_r == CW'(CLKS_PER_BIT - 1));
        data_last_s = (bit_idx_r == IW'(DATA_BITS - 1));
        stop_last_s = (bit_idx_r == IW'(STOP_BITS - 1));
        pop_s       = 1'b0;
        line_s      = 1'b1;
        case (state_r)
            TX_IDLE:   line_s = 1'b1;
            TX_START:  line_s = 1'b0;
            TX_DATA:   line_s = shift_r[0];
            TX_PARITY: line_s = par_r;
            TX_STOP:   line_s = 1'b1;
            default:   line_s = 1'b1;
        endcase
        if (state_r == TX_IDLE) begin
            pop_s = !fifo_empty_s;
        end else if (state_r == TX_STOP && bit_end_s && stop_last_s) begin
            pop_s = !fifo_empty_s;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Serializer FSM with baud and bit counters; tx lags state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= TX_IDLE;
            baud_cnt_r <= {CW{1'b0}};
            bit_idx_r  <= {IW{1'b0}};
            shift_r    <= {DATA_BITS{1'b0}};
            par_r      <= 1'b0;
            tx_r       <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            tx_r   <= line_s;
            done_r <= 1'b0;
            case (state_r)
                TX_IDLE: begin
                    if (pop_s) begin
                        state_r    <= TX_START;
                        baud_cnt_r <= {CW{1'b0}};
                        shift_r    <= fifo_head_s;
                        par_r      <= frame_parity(fifo_head_s);
                    end
                end
                TX_START: begin
                    if (bit_end_s) begin
                        state_r    <= TX_DATA;
                        baud_cnt_r <= {CW{1'b0}};
                        bit_idx_r  <= {IW{1'b0}};
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= {CW{1'b0}};
                        shift_r    <= {1'b0, shift_r[DATA_BITS-1:1]};
                        if (data_last_s) begin
                            bit_idx_r <= {IW{1'b0}};
                            state_r   <= (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + IW'(1);
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CW'(1);
                    end
                end
                TX_PARITY: begin
                    if (bit_end_s) begin
                        state_r    <= TX_STOP;
                        baud_cnt_r <= {CW{1'b0}};
                        bit_idx_r  <= {IW{1'b0}};
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= {CW{1'b0}};
                        if (stop_last_s) begin
                            done_r    <= 1'b1;
                            bit_idx_r <= {IW{1'b0}};
                            if (pop_s) begin
                                state_r <= TX_START;
                                shift_r <= fifo_head_s;
                                par_r   <= frame_parity(fifo_head_s);
                            end else begin
                                state_r <= TX_IDLE;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + IW'(1);
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r    <= TX_IDLE;
                    baud_cnt_r <= {CW{1'b0}};
                    bit_idx_r  <= {IW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Three transmitter configurations checked cycle by cycle against a frame
// schedule model: frame n starts at max(prev start + frame length, accept + 2).
module tb_uart_tx_param;

    localparam int C_P   [3] = '{868, 4, 4};
    localparam int DB_P  [3] = '{8, 7, 8};
    localparam int PAR_P [3] = '{0, 2, 1};
    localparam int SB_P  [3] = '{1, 2, 1};
    localparam int DEP_P [3] = '{16, 4, 4};
    localparam int MAXW      = 128;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_v [3];
    logic [8:0] sdata_v [3];
    logic       ready_v [3];
    logic       tx_v    [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic [4:0] cnt0;
    logic [2:0] cnt1;
    logic [2:0] cnt2;

    always #5 clk = ~clk;

    uart_tx_param #(.CLKS_PER_BIT(C_P[0]), .DATA_BITS(DB_P[0]), .PARITY(PAR_P[0]),
                    .STOP_BITS(SB_P[0]), .FIFO_DEPTH(DEP_P[0])) u_dut0 (
        .clk(clk), .rst(rst), .s_data(sdata_v[0][7:0]), .s_valid(valid_v[0]),
        .s_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]),
        .fifo_count(cnt0));

    uart_tx_param #(.CLKS_PER_BIT(C_P[1]), .DATA_BITS(DB_P[1]), .PARITY(PAR_P[1]),
                    .STOP_BITS(SB_P[1]), .FIFO_DEPTH(DEP_P[1])) u_dut1 (
        .clk(clk), .rst(rst), .s_data(sdata_v[1][6:0]), .s_valid(valid_v[1]),
        .s_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]),
        .fifo_count(cnt1));

    uart_tx_param #(.CLKS_PER_BIT(C_P[2]), .DATA_BITS(DB_P[2]), .PARITY(PAR_P[2]),
                    .STOP_BITS(SB_P[2]), .FIFO_DEPTH(DEP_P[2])) u_dut2 (
        .clk(clk), .rst(rst), .s_data(sdata_v[2][7:0]), .s_valid(valid_v[2]),
        .s_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]),
        .fifo_count(cnt2));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int a_t [3][MAXW];
    int s_t [3][MAXW];
    int d_t [3][MAXW];
    int lo [3];
    int hi [3];
    int burst_left [3];
    bit acc [3];

    function automatic int frame_len(input int i);
        return (1 + DB_P[i] + ((PAR_P[i] != 0) ? 1 : 0) + SB_P[i]) * C_P[i];
    endfunction

    function automatic int m_count(input int i, input int t);
        int c = 0;
        for (int n = lo[i]; n < hi[i]; n++) begin
            if (a_t[i][n] <= t) c++;
            if (s_t[i][n] - 1 <= t) c--;
        end
        return c;
    endfunction

    function automatic int m_tx(input int i, input int t);
        int pos;
        int ones;
        for (int n = lo[i]; n < hi[i]; n++) begin
            if (t >= s_t[i][n] && t < s_t[i][n] + frame_len(i)) begin
                pos  = (t - s_t[i][n]) / C_P[i];
                ones = $countones(d_t[i][n]) & 1;
                if (pos == 0) return 0;
                if (pos <= DB_P[i]) return (d_t[i][n] >> (pos - 1)) & 1;
                if (PAR_P[i] != 0 && pos == DB_P[i] + 1) return (PAR_P[i] == 2) ? ones : 1 - ones;
                return 1;
            end
        end
        return 1;
    endfunction

    function automatic int m_done(input int i, input int t);
        for (int n = lo[i]; n < hi[i]; n++) begin
            if (t == s_t[i][n] + frame_len(i) - 1) return 1;
        end
        return 0;
    endfunction

    function automatic int m_busy(input int i, input int t);
        for (int n = lo[i]; n < hi[i]; n++) begin
            if (a_t[i][n] <= t && t < s_t[i][n] + frame_len(i) - 1) return 1;
        end
        return 0;
    endfunction

    function automatic int dut_count(input int i);
        if (i == 0) return int'(cnt0);
        if (i == 1) return int'(cnt1);
        return int'(cnt2);
    endfunction

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // One clock edge: update the model with what the DUT should have accepted,
    // compare every output, then advance the stimulus.
    task automatic step();
        int mask;
        int prev_end;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            acc[i] = 1'b0;
            if (rst) begin
                lo[i] = hi[i];
            end else if (valid_v[i] && m_count(i, cyc - 1) != DEP_P[i] && hi[i] < MAXW) begin
                acc[i]   = 1'b1;
                mask     = (1 << DB_P[i]) - 1;
                prev_end = (hi[i] > lo[i]) ? s_t[i][hi[i] - 1] + frame_len(i) : 0;
                a_t[i][hi[i]] = cyc;
                d_t[i][hi[i]] = int'(sdata_v[i]) & mask;
                s_t[i][hi[i]] = (prev_end > cyc + 2) ? prev_end : cyc + 2;
                hi[i]++;
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("tx%0d", i), int'(tx_v[i]), m_tx(i, cyc));
            check_val($sformatf("tx_done%0d", i), int'(done_v[i]), m_done(i, cyc));
            check_val($sformatf("busy%0d", i), int'(busy_v[i]), m_busy(i, cyc));
            check_val($sformatf("fifo_count%0d", i), dut_count(i), m_count(i, cyc));
            check_val($sformatf("s_ready%0d", i), int'(ready_v[i]),
                      (m_count(i, cyc) != DEP_P[i]) ? 1 : 0);
            if (acc[i]) begin
                burst_left[i]--;
                sdata_v[i] = 9'($urandom);
            end
            valid_v[i] = (burst_left[i] > 0);
            if (!valid_v[i]) sdata_v[i] = 9'($urandom);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic start_burst(input int i, input int n, input int d);
        burst_left[i] = n;
        valid_v[i]    = 1'b1;
        sdata_v[i]    = 9'(d);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (k < budget && (m_busy(0, cyc) + m_busy(1, cyc) + m_busy(2, cyc) +
                              burst_left[0] + burst_left[1] + burst_left[2]) != 0) begin
            step();
            k++;
        end
        check_val("idle_timeout", (k >= budget) ? 1 : 0, 0);
    endtask

    initial begin
        int base;
        int target;
        int k;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_v[i] = 1'b0; sdata_v[i] = 9'd0; burst_left[i] = 0; lo[i] = 0; hi[i] = 0;
        end
        run(3);
        rst = 1'b0;
        run(2);

        // Directed frames: 0x55 default, 0x03 7E2, 0x01 then 0x00 odd parity.
        start_burst(0, 1, 32'h55);
        start_burst(1, 1, 32'h03);
        start_burst(2, 1, 32'h01);
        run(60);
        start_burst(2, 1, 32'h00);
        run(60);
        start_burst(0, 1, int'($urandom));

        // Held s_valid with six words into depth-4 FIFOs.
        start_burst(1, 6, int'($urandom));
        start_burst(2, 6, int'($urandom));
        run(400);

        repeat (40) begin
            for (int i = 1; i < 3; i++) begin
                if (burst_left[i] == 0 && $urandom_range(0, 2) == 0)
                    start_burst(i, int'($urandom_range(1, 6)), int'($urandom));
            end
            run(int'($urandom_range(5, 60)));
        end
        wait_idle(30000);

        // Reset during the data bits of the second of three queued frames.
        base = hi[1];
        start_burst(1, 3, int'($urandom));
        k = 0;
        while (hi[1] < base + 2 && k < 100) begin step(); k++; end
        check_val("queue_timeout", (hi[1] < base + 2) ? 1 : 0, 0);
        target = s_t[1][base + 1] + C_P[1] + 10;
        k = 0;
        while (cyc < target - 1 && k < 500) begin step(); k++; end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rst_tx", int'(tx_v[1]), 1);
        check_val("rst_count", int'(cnt1), 0);
        check_val("rst_busy", int'(busy_v[1]), 0);
        check_val("rst_ready", int'(ready_v[1]), 1);
        run(150);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
